uart_rx_param: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_param.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority vote
// Valid/ready output register, framing/parity/overrun reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(MID - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(MID);
    localparam logic [CW-1:0] SAMP_C   = CW'(MID + 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_BREAK = 3'd5;

    logic                 rx_meta;
    logic                 srx;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic                 vote_a;
    logic                 vote_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 done;
    logic [DATA_BITS-1:0] done_data;
    logic                 done_fe;
    logic                 done_pe;

    logic voted;
    logic commit;
    logic par_exp;
    logic stop_fe;

    assign voted   = (vote_a & vote_b) | (vote_a & srx) | (vote_b & srx);
    assign commit  = (cnt == SAMP_C);
    assign par_exp = (PARITY == 1) ? ~^shreg : ^shreg;
    assign stop_fe = frm_err | ~voted;
    assign o_busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            srx          <= 1'b1;
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            vote_a       <= 1'b0;
            vote_b       <= 1'b0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            done         <= 1'b0;
            done_data    <= '0;
            done_fe      <= 1'b0;
            done_pe      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            rx_meta   <= rx;
            srx       <= rx_meta;
            done      <= 1'b0;
            o_overrun <= 1'b0;

            if (state != ST_IDLE && state != ST_BREAK)
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            if (cnt == SAMP_A) vote_a <= srx;
            if (cnt == SAMP_B) vote_b <= srx;

            case (state)
                ST_IDLE: begin
                    if (!srx) begin
                        state   <= ST_START;
                        cnt     <= '0;
                        idx     <= '0;
                        frm_err <= 1'b0;
                        par_err <= 1'b0;
                    end
                end
                ST_START: begin
                    if (commit) state <= voted ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (commit) begin
                        shreg <= {voted, shreg[DATA_BITS-1:1]};
                        if (idx == LAST_BIT) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (commit) begin
                        par_err <= (voted != par_exp);
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (commit) begin
                        frm_err <= stop_fe;
                        if (idx == LAST_STOP) begin
                            idx       <= '0;
                            done      <= 1'b1;
                            done_data <= shreg;
                            done_fe   <= stop_fe;
                            done_pe   <= par_err;
                            // a zero word with a bad stop is a line break: hold until the line recovers
                            state     <= (stop_fe && shreg == '0) ? ST_BREAK : ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (srx) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (done) begin
                if (!o_valid || i_ready) begin
                    o_data       <= done_data;
                    o_frame_err  <= done_fe;
                    o_parity_err <= done_pe;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param
// Instance a: 8N1. Instance b: 8 data, even parity, 2 stop bits.
module tb_uart_rx_param;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b;
    logic       rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       va, vb, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   fails  = 0;
    int   ovr_a  = 0;
    int   ovr_b  = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .o_data(data_a), .o_valid(va), .i_ready(rdy_a),
        .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun(ov_a), .o_busy(busy_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .o_data(data_b), .o_valid(vb), .i_ready(rdy_b),
        .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun(ov_b), .o_busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (va && rdy_a) begin
                if (q_a.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL a_unexpected_word: got %0h expected none", data_a);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", 32'(data_a), 32'(e.d));
                    chk("a_frame_err", 32'(fe_a), 32'(e.fe));
                    chk("a_parity_err", 32'(pe_a), 32'(e.pe));
                end
            end
            if (vb && rdy_b) begin
                if (q_b.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL b_unexpected_word: got %0h expected none", data_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", 32'(data_b), 32'(e.d));
                    chk("b_frame_err", 32'(fe_b), 32'(e.fe));
                    chk("b_parity_err", 32'(pe_b), 32'(e.pe));
                end
            end
            if (ov_a) ovr_a++;
            if (ov_b) ovr_b++;
        end
    end

    task automatic drv(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                        input logic par_bit, input int nstop, input logic stop_v);
        drv(sel, 1'b0);
        for (int i = 0; i < 8; i++) drv(sel, d[i]);
        if (par_en) drv(sel, par_bit);
        for (int i = 0; i < nstop; i++) drv(sel, stop_v);
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    task automatic gap(input int nbits);
        repeat (nbits * CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        int k;
        reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", 32'(va), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
        chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        reset = 1'b0;
        gap(2);

        // basic 8N1 word
        q_a.push_back('{8'hA5, 1'b0, 1'b0});
        send(0, 8'hA5, 0, 1'b0, 1, 1'b1);
        gap(2);

        // short start glitch is rejected
        rx_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx_a = 1'b1;
        seen = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy_a) seen = 1;
            else if (seen) break;
        end
        chk("glitch_busy_seen", 32'(seen), 32'd1);
        chk("glitch_busy_fall", 32'(k < 20), 32'd1);
        @(posedge clk); #1;
        gap(2);

        // even parity, two stop bits
        q_b.push_back('{8'h3C, 1'b0, 1'b1});
        send(1, 8'h3C, 1, 1'b1, 2, 1'b1);
        gap(2);
        q_b.push_back('{8'h3C, 1'b0, 1'b0});
        send(1, 8'h3C, 1, 1'b0, 2, 1'b1);
        gap(2);

        // framing error, then a line break, then a clean word
        q_a.push_back('{8'h81, 1'b1, 1'b0});
        send(0, 8'h81, 0, 1'b0, 1, 1'b0);
        gap(2);
        q_a.push_back('{8'h00, 1'b1, 1'b0});
        rx_a = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        rx_a = 1'b1;
        gap(2);
        q_a.push_back('{8'hC3, 1'b0, 1'b0});
        send(0, 8'hC3, 0, 1'b0, 1, 1'b1);
        gap(2);

        // overrun: second word dropped while the first is held
        rdy_a = 1'b0;
        q_a.push_back('{8'h11, 1'b0, 1'b0});
        send(0, 8'h11, 0, 1'b0, 1, 1'b1);
        send(0, 8'h22, 0, 1'b0, 1, 1'b1);
        gap(2);
        chk("ovr_once", 32'(ovr_a), 32'd1);
        chk("held_valid", 32'(va), 32'd1);
        chk("held_data", 32'(data_a), 32'h11);
        rdy_a = 1'b1;
        gap(1);
        rdy_a = 1'b0;

        // accept coincides with completion: no overrun
        q_a.push_back('{8'h11, 1'b0, 1'b0});
        send(0, 8'h11, 0, 1'b0, 1, 1'b1);
        gap(2);
        q_a.push_back('{8'h22, 1'b0, 1'b0});
        fork
            send(0, 8'h22, 0, 1'b0, 1, 1'b1);
            begin
                repeat (157) @(posedge clk);
                #1 rdy_a = 1'b1;
                @(posedge clk);
                #1 rdy_a = 1'b0;
            end
        join
        gap(1);
        chk("simul_no_ovr", 32'(ovr_a), 32'd1);
        chk("simul_valid", 32'(va), 32'd1);
        chk("simul_data", 32'(data_a), 32'h22);
        rdy_a = 1'b1;
        gap(1);

        // reset mid-frame
        rx_a = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_valid", 32'(va), 32'd0);
        gap(2);
        q_a.push_back('{8'h5A, 1'b0, 1'b0});
        send(0, 8'h5A, 0, 1'b0, 1, 1'b1);
        gap(3);

        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        chk("b_no_overrun", 32'(ovr_b), 32'd0);
        chk("a_overrun_total", 32'(ovr_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
